// File: rtl/store_port_arbiter_if.sv
// Signal bundle between the store queue / fill engine / D-cache / MMIO
// side and the store port arbiter. The arbiter uses the master modport;
// the surrounding logic (or a testbench) uses the slave modport.
interface store_port_arbiter_if;

    // Store uop from the store queue
    logic        IN_stValid;
    logic [31:0] IN_stAddr;
    logic [31:0] IN_stData;
    logic [3:0]  IN_stWmask;
    logic        OUT_stallSt;

    // Line-fill beats from the fill engine
    logic        IN_fillValid;
    logic [31:0] IN_fillAddr;
    logic [31:0] IN_fillData;
    logic        OUT_fillReady;

    // D-cache write port
    logic        IN_cacheStall;
    logic        OUT_wrValid;
    logic [31:0] OUT_wrAddr;
    logic [31:0] OUT_wrData;
    logic [3:0]  OUT_wrWmask;
    logic        OUT_wrIsFill;

    // MMIO write port
    logic        OUT_mmioValid;
    logic [31:0] OUT_mmioAddr;
    logic [31:0] OUT_mmioData;
    logic [3:0]  OUT_mmioWmask;
    logic        IN_mmioReady;
    logic        IN_mmioAck;

    // Quiescence indication
    logic        OUT_idle;

    modport master (
        input  IN_stValid, IN_stAddr, IN_stData, IN_stWmask,
        output OUT_stallSt,
        input  IN_fillValid, IN_fillAddr, IN_fillData,
        output OUT_fillReady,
        input  IN_cacheStall,
        output OUT_wrValid, OUT_wrAddr, OUT_wrData, OUT_wrWmask, OUT_wrIsFill,
        output OUT_mmioValid, OUT_mmioAddr, OUT_mmioData, OUT_mmioWmask,
        input  IN_mmioReady, IN_mmioAck,
        output OUT_idle
    );

    modport slave (
        output IN_stValid, IN_stAddr, IN_stData, IN_stWmask,
        input  OUT_stallSt,
        output IN_fillValid, IN_fillAddr, IN_fillData,
        input  OUT_fillReady,
        output IN_cacheStall,
        input  OUT_wrValid, OUT_wrAddr, OUT_wrData, OUT_wrWmask, OUT_wrIsFill,
        input  OUT_mmioValid, OUT_mmioAddr, OUT_mmioData, OUT_mmioWmask,
        output IN_mmioReady, IN_mmioAck,
        input  OUT_idle
    );

endinterface

// File: rtl/store_port_arbiter.sv
// Store port arbiter.
// Shares the single D-cache write port between the store-queue drain and
// the line-fill engine, and steers MMIO stores to a separate MMIO port.
// Fills normally win the cache port; a waiting cache store is forced
// through after STARVE_LIMIT consecutive fill grants. While an MMIO store
// is outstanding (REQ/WAIT) every store is stalled so stores leave in
// queue order; fills keep flowing.
module store_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [3:0]  MMIO_REGION  = 4'hF
) (
    input logic                  clk,
    input logic                  rst,
    store_port_arbiter_if.master bus
);

    localparam int unsigned    CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mmio_state_e;

    mmio_state_e      state;
    mmio_state_e      state_nxt;
    logic [CNT_W-1:0] starve_cnt;

    // Request classification and grants
    logic is_mmio;
    logic cache_st;
    logic st_cand;
    logic mmio_acc;
    logic st_gnt;
    logic fill_gnt;

    // Registered cache write port
    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_wmask;
    logic        wr_is_fill;

    // Registered MMIO port
    logic        mmio_valid;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_data;
    logic [3:0]  mmio_wmask;

    // Classify the incoming store and decide who owns the cache port this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        is_mmio  = 1'b0;
        cache_st = 1'b0;
        st_cand  = 1'b0;
        mmio_acc = 1'b0;
        st_gnt   = 1'b0;
        fill_gnt = 1'b0;

        if (bus.IN_stValid) begin
            is_mmio  = (bus.IN_stAddr[31:28] == MMIO_REGION);
            cache_st = !is_mmio;
        end

        // Nothing may pass an outstanding MMIO store, so both kinds of
        // store only move while the MMIO path is idle.
        st_cand  = cache_st && (state == ST_IDLE);
        mmio_acc = is_mmio  && (state == ST_IDLE);

        // The MMIO port is independent of the cache, so a cache stall
        // only freezes cache arbitration.
        if (!bus.IN_cacheStall) begin
            st_gnt   = st_cand && (!bus.IN_fillValid || (starve_cnt == CNT_MAX));
            fill_gnt = bus.IN_fillValid && !st_gnt;
        end
    end

    // Handshake outputs; reset forces the "nothing accepted" view.
    assign bus.OUT_stallSt   = rst || !(st_gnt || mmio_acc);
    assign bus.OUT_fillReady = !rst && fill_gnt;
    assign bus.OUT_idle      = (state == ST_IDLE) && !wr_valid
                               && !bus.IN_stValid && !bus.IN_fillValid;

    // MMIO FSM next-state: accept in IDLE, hand off in REQ, wait for completion.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (mmio_acc) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // A completion in the same cycle as the handoff skips WAIT.
                if (bus.IN_mmioReady) begin
                    state_nxt = bus.IN_mmioAck ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.IN_mmioAck) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // MMIO FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is written with non-blocking assignments
        // so every register samples the pre-edge values of its inputs.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Count fills that overtake a waiting cache store; frozen while the cache stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!bus.IN_cacheStall) begin
            if (st_gnt || !st_cand) begin
                starve_cnt <= '0;
            end else if (fill_gnt && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end
    end

    // Cache write registers: load the granted beat, drop valid when idle, hold on stall.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: payload registers are reset too, so the write port shows
        // all-zero values after reset rather than X.
        if (rst) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_wmask   <= '0;
            wr_is_fill <= 1'b0;
        end else if (!bus.IN_cacheStall) begin
            if (fill_gnt) begin
                wr_valid   <= 1'b1;
                wr_addr    <= bus.IN_fillAddr;
                wr_data    <= bus.IN_fillData;
                wr_wmask   <= 4'hF;
                wr_is_fill <= 1'b1;
            end else if (st_gnt) begin
                wr_valid   <= 1'b1;
                wr_addr    <= bus.IN_stAddr;
                wr_data    <= bus.IN_stData;
                wr_wmask   <= bus.IN_stWmask;
                wr_is_fill <= 1'b0;
            end else begin
                wr_valid   <= 1'b0;
            end
        end
    end

    // MMIO request registers: capture on accept, hold until the slave takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmio_valid <= 1'b0;
            mmio_addr  <= '0;
            mmio_data  <= '0;
            mmio_wmask <= '0;
        end else if (mmio_acc) begin
            mmio_valid <= 1'b1;
            mmio_addr  <= bus.IN_stAddr;
            mmio_data  <= bus.IN_stData;
            mmio_wmask <= bus.IN_stWmask;
        end else if ((state == ST_REQ) && bus.IN_mmioReady) begin
            mmio_valid <= 1'b0;
        end
    end

    assign bus.OUT_wrValid   = wr_valid;
    assign bus.OUT_wrAddr    = wr_addr;
    assign bus.OUT_wrData    = wr_data;
    assign bus.OUT_wrWmask   = wr_wmask;
    assign bus.OUT_wrIsFill  = wr_is_fill;

    assign bus.OUT_mmioValid = mmio_valid;
    assign bus.OUT_mmioAddr  = mmio_addr;
    assign bus.OUT_mmioData  = mmio_data;
    assign bus.OUT_mmioWmask = mmio_wmask;

endmodule
